// File: rtl/video_timing_pkg.sv
// Shared types, default PAL-at-12MHz timing and width helpers for the
// composite video timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    BROAD,
    POST_EQ,
    LINES,
    PRE_EQ
  } vstate_t;

  // PAL composite timing at a 12 MHz clock
  localparam int PAL_CLK_PER_LINE     = 768;
  localparam int PAL_HSYNC_LEN        = 57;
  localparam int PAL_BROAD_LEN        = 327;
  localparam int PAL_SHORT_LEN        = 29;
  localparam int PAL_FIELD_HALF_LINES = 625;
  localparam int PAL_NUM_BROAD        = 5;
  localparam int PAL_NUM_POST_EQ      = 5;
  localparam int PAL_NUM_PRE_EQ       = 5;
  localparam int PAL_ACTIVE_X_START   = 188;
  localparam int PAL_ACTIVE_W         = 499;
  localparam int PAL_ACTIVE_Y_START   = 51;
  localparam int PAL_ACTIVE_H         = 230;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// DEPTH=0 degenerates to a plain wire.
module video_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    // clk/rst have no job in the zero-depth case
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; clear empties the whole line.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Composite video timing generator: sync/white levels plus pixel
// coordinates issued ahead of the output by PIXEL_LATENCY clocks.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_PER_LINE     = PAL_CLK_PER_LINE,
  parameter int HSYNC_LEN        = PAL_HSYNC_LEN,
  parameter int BROAD_LEN        = PAL_BROAD_LEN,
  parameter int SHORT_LEN        = PAL_SHORT_LEN,
  parameter int FIELD_HALF_LINES = PAL_FIELD_HALF_LINES,
  parameter int NUM_BROAD        = PAL_NUM_BROAD,
  parameter int NUM_POST_EQ      = PAL_NUM_POST_EQ,
  parameter int NUM_PRE_EQ       = PAL_NUM_PRE_EQ,
  parameter int ACTIVE_X_START   = PAL_ACTIVE_X_START,
  parameter int ACTIVE_W         = PAL_ACTIVE_W,
  parameter int ACTIVE_Y_START   = PAL_ACTIVE_Y_START,
  parameter int ACTIVE_H         = PAL_ACTIVE_H,
  parameter int PIXEL_LATENCY    = 0,
  parameter int X_W              = 9,
  parameter int Y_W              = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_pixel,
  output logic           o_sync,
  output logic           o_white,
  output logic           o_enable,
  output logic [X_W-1:0] o_pixel_x,
  output logic [Y_W-1:0] o_pixel_y,
  output logic           o_field,
  output logic           o_frame_start
);

  localparam int HALF = CLK_PER_LINE / 2;
  localparam int H_W  = cnt_w(CLK_PER_LINE);
  localparam int V_W  = cnt_w(FIELD_HALF_LINES);
  localparam int L_W  = cnt_w(FIELD_HALF_LINES / 2 + 1);

  logic [H_W-1:0] h_q, h_d, hh;
  logic [V_W-1:0] v_q, v_d;
  logic [L_W-1:0] l_q, l_d;
  logic           field_q, field_d;
  vstate_t        vstate;
  logic           raw_tip, active;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;

  // Coordinate-aligned stage; tip is sync inverted so a cleared line means "no sync"
  logic           tip_q, enable_q, field_o_q, frame_start_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           tip_dly, en_dly;
  logic           sync_q, white_q;

  // Next counter state: h wraps per line, v steps on every half-line boundary.
  always_comb begin
    h_d     = (h_q == H_W'(CLK_PER_LINE - 1)) ? '0 : h_q + H_W'(1);
    v_d     = v_q;
    l_d     = l_q;
    field_d = field_q;
    if (h_d == '0 || h_d == H_W'(HALF)) begin
      if (v_q == V_W'(FIELD_HALF_LINES - 1)) begin
        v_d     = '0;
        l_d     = '0;
        field_d = ~field_q;
      end else begin
        v_d = v_q + V_W'(1);
        if (h_d == '0) l_d = l_q + L_W'(1);
      end
    end
  end

  // Decode vertical state, sync tip and active window from the counters.
  always_comb begin
    if (int'(v_q) < NUM_BROAD)                          vstate = BROAD;
    else if (int'(v_q) < NUM_BROAD + NUM_POST_EQ)       vstate = POST_EQ;
    else if (int'(v_q) >= FIELD_HALF_LINES - NUM_PRE_EQ) vstate = PRE_EQ;
    else                                                vstate = LINES;

    // position inside the current half-line
    hh = (int'(h_q) >= HALF) ? h_q - H_W'(HALF) : h_q;

    case (vstate)
      BROAD:           raw_tip = int'(hh) < BROAD_LEN;
      POST_EQ, PRE_EQ: raw_tip = int'(hh) < SHORT_LEN;
      default:         raw_tip = int'(h_q) < HSYNC_LEN;
    endcase

    active = (vstate == LINES)
          && int'(l_q) >= ACTIVE_Y_START && int'(l_q) < ACTIVE_Y_START + ACTIVE_H
          && int'(h_q) >= ACTIVE_X_START && int'(h_q) < ACTIVE_X_START + ACTIVE_W;
    pix_x = X_W'(int'(h_q) - ACTIVE_X_START);
    pix_y = Y_W'(int'(l_q) - ACTIVE_Y_START);
  end

  // Counters and the registered coordinate stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_q           <= '0;
      v_q           <= '0;
      l_q           <= '0;
      field_q       <= 1'b0;
      tip_q         <= 1'b0;
      enable_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      field_o_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      l_q           <= l_d;
      field_q       <= field_d;
      tip_q         <= raw_tip;
      enable_q      <= active;
      x_q           <= active ? pix_x : '0;
      y_q           <= active ? pix_y : '0;
      field_o_q     <= field_q;
      frame_start_q <= (h_q == '0) && (v_q == '0) && !field_q;
    end
  end

  video_delay_line #(
    .WIDTH (2),
    .DEPTH (PIXEL_LATENCY)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({tip_q, enable_q}),
    .q_o ({tip_dly, en_dly})
  );

  // Output levels: sync and white leave together, after the pixel fetch latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 1'b1;
      white_q <= 1'b0;
    end else begin
      sync_q  <= ~tip_dly;
      white_q <= en_dly & i_pixel;
    end
  end

  assign o_sync        = sync_q;
  assign o_white       = white_q;
  assign o_enable      = enable_q;
  assign o_pixel_x     = x_q;
  assign o_pixel_y     = y_q;
  assign o_field       = field_o_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default PAL timing (latency 0 and 2) plus two scaled
// configurations (interlaced and progressive) for whole-frame behaviour.
module tb_video_timing_gen;

  logic clk;
  logic rst_a, rst_s;
  logic pix0, pix2, pixs, pixe;

  logic s0, w0, e0, f0, fs0;
  logic [8:0] x0;
  logic [7:0] y0;
  logic s2, w2, e2, f2, fs2;
  logic [8:0] x2;
  logic [7:0] y2;
  logic ss, ws, es, fsl, fss;
  logic [5:0] xs;
  logic [3:0] ys;
  logic se, we, ee, fe, fse;
  logic [5:0] xe;
  logic [3:0] ye;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen dut0 (
    .clk(clk), .rst(rst_a), .i_pixel(pix0), .o_sync(s0), .o_white(w0), .o_enable(e0),
    .o_pixel_x(x0), .o_pixel_y(y0), .o_field(f0), .o_frame_start(fs0));

  video_timing_gen #(.PIXEL_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst_a), .i_pixel(pix2), .o_sync(s2), .o_white(w2), .o_enable(e2),
    .o_pixel_x(x2), .o_pixel_y(y2), .o_field(f2), .o_frame_start(fs2));

  video_timing_gen #(
    .CLK_PER_LINE(64), .HSYNC_LEN(5), .BROAD_LEN(27), .SHORT_LEN(3), .FIELD_HALF_LINES(25),
    .NUM_BROAD(3), .NUM_POST_EQ(2), .NUM_PRE_EQ(2), .ACTIVE_X_START(10), .ACTIVE_W(40),
    .ACTIVE_Y_START(4), .ACTIVE_H(5), .PIXEL_LATENCY(0), .X_W(6), .Y_W(4)
  ) dut_s (
    .clk(clk), .rst(rst_s), .i_pixel(pixs), .o_sync(ss), .o_white(ws), .o_enable(es),
    .o_pixel_x(xs), .o_pixel_y(ys), .o_field(fsl), .o_frame_start(fss));

  video_timing_gen #(
    .CLK_PER_LINE(64), .HSYNC_LEN(5), .BROAD_LEN(27), .SHORT_LEN(3), .FIELD_HALF_LINES(24),
    .NUM_BROAD(3), .NUM_POST_EQ(2), .NUM_PRE_EQ(2), .ACTIVE_X_START(10), .ACTIVE_W(40),
    .ACTIVE_Y_START(4), .ACTIVE_H(5), .PIXEL_LATENCY(0), .X_W(6), .Y_W(4)
  ) dut_e (
    .clk(clk), .rst(rst_a), .i_pixel(pixe), .o_sync(se), .o_white(we), .o_enable(ee),
    .o_pixel_x(xe), .o_pixel_y(ye), .o_field(fe), .o_frame_start(fse));

  typedef struct {
    int   cyc;
    logic sync;
    logic white;
    logic en;
    int   x;
    int   y;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int c, input logic s, input logic w, input logic e,
                     input int x, input int y);
    vec_t v;
    v.cyc = c; v.sync = s; v.white = w; v.en = e; v.x = x; v.y = y;
    vecs.push_back(v);
  endtask

  initial begin
    int vi;
    int run_start, r, exp_len, exp_start;
    logic prev_s0;
    int fs_cnt, fs_last, en_f0, en_f1, excl0, excls;

    // sample index j: outputs seen after the j-th edge following release;
    // coords describe counter state j, o_sync (latency 0) state j-1
    add(0,     1'b1, 1'b0, 1'b0, 0,   0);
    add(1,     1'b0, 1'b0, 1'b0, 0,   0);
    add(327,   1'b0, 1'b0, 1'b0, 0,   0);
    add(328,   1'b1, 1'b0, 1'b0, 0,   0);
    add(385,   1'b0, 1'b0, 1'b0, 0,   0);
    add(711,   1'b0, 1'b0, 1'b0, 0,   0);
    add(712,   1'b1, 1'b0, 1'b0, 0,   0);
    add(1921,  1'b0, 1'b0, 1'b0, 0,   0);
    add(1949,  1'b0, 1'b0, 1'b0, 0,   0);
    add(1950,  1'b1, 1'b0, 1'b0, 0,   0);
    add(3897,  1'b0, 1'b0, 1'b0, 0,   0);
    add(3898,  1'b1, 1'b0, 1'b0, 0,   0);
    add(4225,  1'b1, 1'b0, 1'b0, 0,   0);
    add(38700, 1'b1, 1'b0, 1'b0, 0,   0);
    add(39355, 1'b1, 1'b0, 1'b0, 0,   0);
    add(39356, 1'b1, 1'b0, 1'b1, 0,   0);
    add(39357, 1'b1, 1'b1, 1'b1, 1,   0);
    add(39854, 1'b1, 1'b1, 1'b1, 498, 0);
    add(39855, 1'b1, 1'b1, 1'b0, 0,   0);
    add(39856, 1'b1, 1'b0, 1'b0, 0,   0);
    add(40136, 1'b1, 1'b1, 1'b1, 12,  1);

    pix0 = 1'b1; pix2 = 1'b0; pixs = 1'b1; pixe = 1'b1;
    rst_a = 1'b0; rst_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sync", s0, 1);
    chk("reset_white", w0, 0);
    chk("reset_enable", e0, 0);
    chk("reset_frame_start", fs0, 0);
    rst_a = 1'b1; rst_s = 1'b1;

    vi = 0; r = 0; run_start = 0; prev_s0 = 1'b1;
    fs_cnt = 0; fs_last = 0; en_f0 = 0; en_f1 = 0; excl0 = 0; excls = 0;

    for (int j = 0; j <= 40200; j++) begin
      @(posedge clk);
      @(negedge clk);

      while (vi < vecs.size() && vecs[vi].cyc == j) begin
        chk($sformatf("vec%0d_sync", j),  s0, vecs[vi].sync);
        chk($sformatf("vec%0d_white", j), w0, vecs[vi].white);
        chk($sformatf("vec%0d_en", j),    e0, vecs[vi].en);
        chk($sformatf("vec%0d_x", j),     x0, vecs[vi].x);
        chk($sformatf("vec%0d_y", j),     y0, vecs[vi].y);
        vi++;
      end

      if (j == 0) chk("frame_start_first", fs0, 1);
      if (j == 1) chk("frame_start_one_clock", fs0, 0);
      if (!s0 && w0) excl0++;

      // sync pulse lengths and positions through the start of field 0
      if (j <= 12000) begin
        if (prev_s0 && !s0) run_start = j;
        if (!prev_s0 && s0 && r < 20) begin
          exp_len   = (r < 10) ? ((r < 5) ? 327 : 29) : 57;
          exp_start = (r < 10) ? 1 + r * 384 : 1 + 3840 + (r - 10) * 768;
          chk($sformatf("pulse%0d_len", r),   j - run_start, exp_len);
          chk($sformatf("pulse%0d_start", r), run_start, exp_start);
          r++;
        end
        prev_s0 = s0;
        if (j == 12000) chk("pulse_count", r, 20);
      end

      // latency 2 instance
      if (j == 0) chk("lat2_frame_start", fs2, 1);
      if (j == 2) chk("lat2_sync_before_fall", s2, 1);
      if (j == 3) chk("lat2_sync_fall", s2, 0);
      if (j == 329) chk("lat2_broad_end_low", s2, 0);
      if (j == 330) chk("lat2_broad_end_high", s2, 1);
      if (j == 39355) chk("lat2_en_before", e2, 0);
      if (j == 39356) chk("lat2_en_rise", e2, 1);
      if (j == 39358) chk("lat2_white_early", w2, 0);
      if (j == 39359) chk("lat2_white_pulse", w2, 1);
      if (j == 39360) chk("lat2_white_after", w2, 0);
      if (j == 39358) pix2 = 1'b1;
      if (j == 39359) pix2 = 1'b0;

      // scaled interlaced instance: 1600-clock frames
      if (j <= 3300) begin
        if (fss) begin
          chk($sformatf("small_fs_at%0d", j), j - fs_last, (fs_cnt == 0) ? 0 : 1600);
          fs_last = j;
          fs_cnt++;
        end
        if (!ss && ws) excls++;
        if (j == 3300) chk("small_fs_count", fs_cnt, 3);
      end
      if (j < 800 && es) en_f0++;
      if (j >= 800 && j < 1600 && es) en_f1++;
      if (j == 1599) begin
        chk("small_en_field0", en_f0, 200);
        chk("small_en_field1", en_f1, 200);
      end
      if (j == 799)  chk("small_field_799", fsl, 0);
      if (j == 800)  chk("small_field_800", fsl, 1);
      if (j == 1599) chk("small_field_1599", fsl, 1);
      if (j == 1600) chk("small_field_1600", fsl, 0);
      if (j == 800)  chk("small_f1_sync_pre", ss, 1);
      if (j == 801)  chk("small_f1_broad_fall", ss, 0);
      if (j == 827)  chk("small_f1_broad_last", ss, 0);
      if (j == 828)  chk("small_f1_broad_end", ss, 1);
      if (j == 561) begin
        chk("small_last_line_en", es, 1);
        chk("small_last_line_x", xs, 39);
        chk("small_last_line_y", ys, 4);
      end
      if (j == 586) chk("small_line_past_window", es, 0);
      if (j == 1034) begin
        chk("small_f1_first_en", es, 1);
        chk("small_f1_first_x", xs, 0);
        chk("small_f1_first_y", ys, 0);
        chk("small_f1_first_field", fsl, 1);
      end

      // scaled progressive instance: every field starts at h=0
      if (j == 767)  chk("prog_field_767", fe, 0);
      if (j == 768)  chk("prog_field_768", fe, 1);
      if (j == 768)  chk("prog_sync_pre", se, 1);
      if (j == 769)  chk("prog_f1_broad_fall", se, 0);
      if (j == 1535) chk("prog_fs_1535", fse, 0);
      if (j == 1536) chk("prog_fs_1536", fse, 1);
    end

    chk("sync_white_exclusive_default", excl0, 0);
    chk("sync_white_exclusive_small", excls, 0);

    // mid-frame reset on the scaled instance, taken inside field 1
    @(negedge clk);
    rst_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b1;
    for (int j = 0; j <= 1172; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1172) begin
        chk("mid_pre_en", es, 1);
        chk("mid_pre_x", xs, 10);
        chk("mid_pre_y", ys, 2);
        chk("mid_pre_field", fsl, 1);
      end
    end
    rst_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_en", es, 0);
    chk("mid_rst_x", xs, 0);
    chk("mid_rst_y", ys, 0);
    chk("mid_rst_sync", ss, 1);
    chk("mid_rst_white", ws, 0);
    chk("mid_rst_field", fsl, 0);
    chk("mid_rst_fs", fss, 0);
    rst_s = 1'b1;
    for (int j = 0; j <= 28; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0) begin
        chk("restart_fs", fss, 1);
        chk("restart_field", fsl, 0);
      end
      if (j == 1)  chk("restart_broad_fall", ss, 0);
      if (j == 27) chk("restart_broad_last", ss, 0);
      if (j == 28) chk("restart_broad_end", ss, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
